// File: rtl/msdf_avmm_responder.sv
// msdf_avmm_responder: Avalon-MM register front end that streams MSDF operands and buffers result digits (optional irq via MSDF_AVMM_IRQ_EN)
module msdf_avmm_responder #(
  parameter int DIGIT_W    = 4,
  parameter int N_DIGITS   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  output logic               avs_readdatavalid,
  output logic               avs_waitrequest,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [DIGIT_W-1:0] op_x,
  output logic [DIGIT_W-1:0] op_y,
  output logic               op_last,
  input  logic               res_valid,
  input  logic [DIGIT_W-1:0] res_digit,
  input  logic               res_last,
  output logic               irq
);
  localparam int OW = N_DIGITS * DIGIT_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(N_DIGITS + 1);
  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;
  state_t             r_state;
  logic [IW-1:0]      r_idx;
  logic [OW-1:0]      r_sx, r_sy;
  logic [31:0]        r_x, r_y, r_rdata;
  logic               r_op_valid, r_op_last, r_done, r_ovf, r_rvalid;
  logic [AW:0]        r_cnt;
  logic [AW-1:0]      r_wp, r_rp;
  logic [DIGIT_W:0]   r_mem [FIFO_DEPTH];
  logic               w_busy, w_stall, w_wr, w_start, w_clr, w_pop, w_full, w_push, w_fin, w_irq_en;
  logic [DIGIT_W:0]   w_head;
  logic [31:0]        w_status, w_res, w_rdata;
  assign w_busy   = r_state != IDLE;
  assign w_stall  = avs_write & w_busy & ((avs_address == 3'd0 & avs_writedata[0]) | avs_address == 3'd2 | avs_address == 3'd3);
  assign w_wr     = avs_write & !w_stall;
  assign w_clr    = w_wr & avs_address == 3'd0 & avs_writedata[1];
  assign w_start  = w_wr & avs_address == 3'd0 & avs_writedata[0] & !avs_writedata[1];
  assign w_pop    = avs_read & avs_address == 3'd4 & r_cnt != '0;
  assign w_full   = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign w_push   = res_valid & (!w_full | w_pop) & !w_clr;
  assign w_fin    = r_state == DRAIN & res_valid & res_last;
  assign w_head   = r_mem[r_rp];
  assign w_status = {19'd0, 5'(r_cnt), 5'd0, r_ovf, r_done, w_busy};
  assign w_res    = r_cnt == '0 ? 32'h8000_0000 : {1'b0, w_head[DIGIT_W], 30'(w_head[DIGIT_W-1:0])};
  assign w_rdata  = avs_address == 3'd0 ? {29'd0, w_irq_en, 2'd0} :
                    avs_address == 3'd1 ? w_status :
                    avs_address == 3'd2 ? r_x :
                    avs_address == 3'd3 ? r_y :
                    avs_address == 3'd4 ? w_res : 32'd0;
  assign avs_waitrequest   = w_stall;
  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rvalid;
  assign op_valid = r_op_valid;
  assign op_last  = r_op_last;
  assign op_x     = r_sx[OW-1 -: DIGIT_W];
  assign op_y     = r_sy[OW-1 -: DIGIT_W];
`ifdef MSDF_AVMM_IRQ_EN
  logic r_irq_en;
  // interrupt enable follows every accepted CTRL write
  always_ff @(posedge clk)
    if (reset) r_irq_en <= 1'b0;
    else if (w_wr & avs_address == 3'd0) r_irq_en <= avs_writedata[2];
  assign w_irq_en = r_irq_en;
  assign irq      = r_irq_en & r_done;
`else
  assign w_irq_en = 1'b0;
  assign irq      = 1'b0;
`endif
  // operand sequencer: shift registers present the current MSD, CLEAR aborts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_op_valid <= 1'b0;
      r_op_last  <= 1'b0;
    end else if (w_clr) begin
      r_state    <= IDLE;
      r_op_valid <= 1'b0;
      r_op_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_state    <= SEND;
          r_idx      <= '0;
          r_sx       <= r_x[OW-1:0];
          r_sy       <= r_y[OW-1:0];
          r_op_valid <= 1'b1;
          r_op_last  <= N_DIGITS == 1;
        end
        SEND: if (op_ready) begin
          r_idx     <= r_idx + 1'b1;
          r_sx      <= r_sx << DIGIT_W;
          r_sy      <= r_sy << DIGIT_W;
          r_op_last <= int'(r_idx) + 2 == N_DIGITS;
          if (r_op_last) begin
            r_state    <= DRAIN;
            r_op_valid <= 1'b0;
            r_op_last  <= 1'b0;
          end
        end
        default: if (w_fin) r_state <= IDLE;
      endcase
    end
  end
  // result FIFO bookkeeping plus sticky DONE/OVERFLOW flags
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_cnt  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_start) r_done <= 1'b0;
      else if (w_fin) r_done <= 1'b1;
      if (res_valid & w_full & !w_pop) r_ovf <= 1'b1;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // FIFO storage needs no reset; the pointers define its contents
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {res_last, res_digit};
  // operand registers and the one-cycle read response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_wr & avs_address == 3'd2) r_x <= avs_writedata;
      if (w_wr & avs_address == 3'd3) r_y <= avs_writedata;
      r_rvalid <= avs_read;
      r_rdata  <= avs_read ? w_rdata : 32'd0;
    end
  end
endmodule

// File: tb/tb_msdf_avmm_responder.sv
// tb_msdf_avmm_responder: scoreboard bench for the MSDF Avalon-MM responder
module tb_msdf_avmm_responder;
`ifdef MSDF_AVMM_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b1;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0, avs_readdata;
  logic        avs_readdatavalid, avs_waitrequest;
  logic        op_valid, op_ready = 1'b0, op_last;
  logic [3:0]  op_x, op_y;
  logic        res_valid = 1'b0, res_last = 1'b0;
  logic [3:0]  res_digit = '0;
  logic        irq;
  int          checks = 0, failures = 0, send_cyc = 0, n;
  logic [31:0] rq_exp [$];
  string       rq_tag [$];
  logic [8:0]  opq [$];
  msdf_avmm_responder dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
    .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x), .op_y(op_y), .op_last(op_last),
    .res_valid(res_valid), .res_digit(res_digit), .res_last(res_last), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d, output int stalls);
    avs_address = a; avs_writedata = d; avs_write = 1'b1; stalls = 0;
    @(negedge clk);
    while (avs_waitrequest && stalls < 200) begin stalls++; @(negedge clk); end
    if (stalls >= 200) chk("wr_timeout", 1, 0);
    @(posedge clk); #1 avs_write = 1'b0;
  endtask
  task automatic wr0(input logic [2:0] a, input logic [31:0] d);
    int s;
    wr(a, d, s);
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    rq_exp.push_back(exp); rq_tag.push_back(tag);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1 avs_read = 1'b0;
  endtask
  task automatic res(input logic [3:0] d, input logic l);
    res_valid = 1'b1; res_digit = d; res_last = l;
    @(posedge clk); #1 res_valid = 1'b0; res_last = 1'b0;
  endtask
  task automatic push_ops(input logic [31:0] x, input logic [31:0] y);
    for (int k = 0; k < 8; k++) opq.push_back({k == 7, x[31-4*k -: 4], y[31-4*k -: 4]});
  endtask
  task automatic wait_send_done();
    int t = 0;
    @(negedge clk);
    while (op_valid && t < 100) begin t++; @(negedge clk); end
    if (t >= 100) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (op_valid) send_cyc++;
    if (op_valid && opq.size() == 0) chk("op_unexpected", 1, 0);
    else if (op_valid && op_ready) chk("op_digit", {23'd0, op_last, op_x, op_y}, {23'd0, opq.pop_front()});
    else if (op_valid) chk("op_hold", {23'd0, op_last, op_x, op_y}, {23'd0, opq[0]});
    if (avs_readdatavalid) begin
      if (rq_exp.size() == 0) chk("rd_unexpected", 1, 0);
      else chk(rq_tag.pop_front(), avs_readdata, rq_exp.pop_front());
    end
  end
  initial begin
    #500000 $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_rvalid", avs_readdatavalid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_wait", avs_waitrequest, 0);
    chk("rst_rdata", avs_readdata, 0);
    @(posedge clk); #1 reset = 1'b0;
    rd(3'd1, 32'h0, "status_reset");
    op_ready = 1'b1;
    wr0(3'd2, 32'h1234_5678);
    wr0(3'd3, 32'h9ABC_DEF0);
    rd(3'd2, 32'h1234_5678, "x_readback");
    rd(3'd6, 32'h0, "unmapped_rd");
    push_ops(32'h1234_5678, 32'h9ABC_DEF0);
    send_cyc = 0;
    wr0(3'd0, 32'h1);
    wait_send_done();
    chk("send_len", send_cyc, 8);
    rd(3'd1, 32'h1, "status_busy");
    res(4'h3, 1'b0); res(4'h5, 1'b0); res(4'h7, 1'b1);
    rd(3'd1, 32'h302, "status_done");
    rd(3'd4, 32'h3, "res0");
    rd(3'd4, 32'h5, "res1");
    rd(3'd4, 32'h4000_0007, "res2");
    rd(3'd4, 32'h8000_0000, "res_empty");
    @(negedge clk) chk("irq_disabled", irq, 0);
    @(posedge clk); #1;
    wr0(3'd2, 32'h0F1E_2D3C);
    wr0(3'd3, 32'h4B5A_6978);
    push_ops(32'h0F1E_2D3C, 32'h4B5A_6978);
    send_cyc = 0;
    wr0(3'd0, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1 op_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 op_ready = 1'b1;
    wait_send_done();
    chk("send_len_stall", send_cyc, 11);
    fork
      wr(3'd2, 32'hCAFE_F00D, n);
      begin repeat (5) @(posedge clk); #1 res(4'h9, 1'b1); end
    join
    chk("stall_cycles", n, 6);
    rd(3'd4, 32'h4000_0009, "res_drain");
    rd(3'd2, 32'hCAFE_F00D, "x_after_stall");
    rd(3'd1, 32'h2, "status_idle_done");
    for (int i = 0; i < 17; i++) res(4'(i), 1'b0);
    rd(3'd1, 32'h1006, "status_ovf");
    fork
      rd(3'd4, 32'h0, "pop_full");
      res(4'h1, 1'b0);
    join
    rd(3'd1, 32'h1006, "status_pushpop");
    wr0(3'd0, 32'h2);
    rd(3'd1, 32'h0, "status_clear");
    op_ready = 1'b0;
    push_ops(32'hCAFE_F00D, 32'h4B5A_6978);
    wr0(3'd0, 32'h1);
    @(posedge clk); #1;
    wr0(3'd0, 32'h2);
    @(negedge clk) chk("abort_valid", op_valid, 0);
    opq.delete();
    @(posedge clk); #1;
    rd(3'd1, 32'h0, "status_abort");
    op_ready = 1'b1;
    wr0(3'd0, 32'h4);
    rd(3'd0, IRQ ? 32'h4 : 32'h0, "ctrl_irq_en");
    push_ops(32'hCAFE_F00D, 32'h4B5A_6978);
    wr0(3'd0, 32'h5);
    wait_send_done();
    chk("irq_before", irq, 0);
    res(4'h1, 1'b1);
    @(negedge clk) chk("irq_rise", irq, IRQ);
    @(posedge clk); #1;
    wr0(3'd0, 32'h6);
    @(negedge clk) chk("irq_fall", irq, 0);
    @(posedge clk); #1;
    rd(3'd0, IRQ ? 32'h4 : 32'h0, "ctrl_after_clear");
    rd(3'd1, 32'h0, "status_after_clear");
    res(4'h5, 1'b0);
    op_ready = 1'b0;
    push_ops(32'hCAFE_F00D, 32'h4B5A_6978);
    wr0(3'd0, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk) chk("rst_mid_valid", op_valid, 0);
    opq.delete();
    @(posedge clk); #1;
    rd(3'd1, 32'h0, "status_post_rst");
    rd(3'd4, 32'h8000_0000, "fifo_post_rst");
    rd(3'd2, 32'h0, "x_post_rst");
    repeat (4) @(posedge clk);
    chk("rd_drain", rq_exp.size(), 0);
    chk("op_drain", opq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
